acq_decimator: RTL

Acquisition decimator sitting directly downstream of the `iir_df_i` anti-alias filter in each analogue channel. It reduces the filtered sample stream by a run-time ratio using one of three scope acquisition modes: sample, peak-detect (min/max) or average. The decimated min/max pair feeds the capture buffer writer. It emits one output pair per completed frame of `ratio` valid input samples.

---
 rtl/acq_pkg.sv | 25 ++
 rtl/acq_minmax.sv | 39 +++
 rtl/acq_decimator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared acquisition definitions: mode encodings and the raw-mode decode helper.
package acq_pkg;

  localparam int unsigned ACQ_MODE_WIDTH = 2;

  typedef enum logic [ACQ_MODE_WIDTH-1:0] {
    ACQ_MODE_SAMPLE = 2'd0,
    ACQ_MODE_PEAK   = 2'd1,
    ACQ_MODE_AVG    = 2'd2,
    ACQ_MODE_RSVD   = 2'd3
  } acq_mode_e;

  // Reserved folds to sample; average folds to sample when the averager is not built.
  function automatic acq_mode_e acq_mode_decode(input logic [ACQ_MODE_WIDTH-1:0] raw,
                                                input logic                      avg_en);
    acq_mode_e m;
    unique case (raw)
      2'd1:    m = ACQ_MODE_PEAK;
      2'd2:    m = avg_en ? ACQ_MODE_AVG : ACQ_MODE_SAMPLE;
      default: m = ACQ_MODE_SAMPLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/acq_minmax.sv
// Signed running min/max tracker. run_min/run_max already include the current din
// when init or update is asserted; the registered state advances on the same edge.
module acq_minmax #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         init,
  input  logic                         update,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] run_min,
  output logic signed [DATA_WIDTH-1:0] run_max
);

  logic signed [DATA_WIDTH-1:0] min_q, max_q;

  always_comb begin
    run_min = min_q;
    run_max = max_q;
    if (init) begin
      run_min = din;
      run_max = din;
    end else if (update) begin
      if (din < min_q) run_min = din;
      if (din > max_q) run_max = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else if (init || update) begin
      min_q <= run_min;
      max_q <= run_max;
    end
  end

endmodule

// File: rtl/acq_decimator.sv
// Acquisition decimator: sample / peak-detect / average over frames of valid samples.
// Define ACQ_DECIMATOR_AVG_EN to build the average mode (accumulator and shifter).
module acq_decimator
  import acq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RATIO_WIDTH = 16,
  parameter int unsigned MAX_SHIFT   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DATA_WIDTH-1:0]  din,
  input  logic                          din_valid,
  input  logic                          clr,
  input  logic [ACQ_MODE_WIDTH-1:0]     mode,
  input  logic [RATIO_WIDTH-1:0]        ratio,
  input  logic [4:0]                    avg_shift,
  output logic signed [DATA_WIDTH-1:0]  dout_min,
  output logic signed [DATA_WIDTH-1:0]  dout_max,
  output logic                          dout_valid
);

`ifdef ACQ_DECIMATOR_AVG_EN
  localparam logic        AvgEn = 1'b1;
  // Counter must reach 2^MAX_SHIFT-1 in average mode as well as ratio-1.
  localparam int unsigned CntW  = (RATIO_WIDTH > MAX_SHIFT) ? RATIO_WIDTH : MAX_SHIFT;
`else
  localparam logic        AvgEn = 1'b0;
  localparam int unsigned CntW  = RATIO_WIDTH;
  localparam int unsigned UnusedMaxShift = MAX_SHIFT;
  logic unused_avg_shift;
  assign unused_avg_shift = ^avg_shift;
`endif

  logic [CntW-1:0]              cnt_q, cnt_d, cnt_eff;
  logic [CntW-1:0]              last_q, last_new, last_sel;
  acq_mode_e                    mode_q, mode_new, mode_sel;
  logic                         frame_start, frame_end;
  logic signed [DATA_WIDTH-1:0] first_q, first_sel;
  logic signed [DATA_WIDTH-1:0] run_min, run_max;
  logic signed [DATA_WIDTH-1:0] res_min, res_max;
  logic signed [DATA_WIDTH-1:0] dout_min_q, dout_max_q;
  logic                         dout_valid_q;

  // clr restarts the frame, so the sample arriving with it is a frame start.
  assign cnt_eff     = clr ? '0 : cnt_q;
  assign frame_start = din_valid && (cnt_eff == '0);
  assign mode_new    = acq_mode_decode(mode, AvgEn);
  assign mode_sel    = frame_start ? mode_new : mode_q;
  assign last_sel    = frame_start ? last_new : last_q;
  assign frame_end   = din_valid && (cnt_eff == last_sel);
  assign first_sel   = frame_start ? din : first_q;

`ifdef ACQ_DECIMATOR_AVG_EN
  localparam int unsigned AccW = DATA_WIDTH + MAX_SHIFT;

  logic [4:0]                   shift_q, shift_new, shift_sel;
  logic signed [AccW-1:0]       acc_q, acc_d, din_ext;
  logic signed [DATA_WIDTH-1:0] avg_res;

  assign shift_new = (32'(avg_shift) > MAX_SHIFT) ? 5'(MAX_SHIFT) : avg_shift;
  assign shift_sel = frame_start ? shift_new : shift_q;
  assign din_ext   = AccW'(din);
  assign acc_d     = frame_start ? din_ext : acc_q + din_ext;
  // A frame of 2^shift samples averages back into the input range, so truncation is exact.
  assign avg_res   = DATA_WIDTH'(acc_d >>> shift_sel);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      acc_q   <= '0;
    end else begin
      if (frame_start) shift_q <= shift_new;
      if (din_valid)   acc_q   <= acc_d;
    end
  end
`endif

  always_comb begin
    last_new = (ratio == '0) ? '0 : CntW'(ratio) - CntW'(1);
`ifdef ACQ_DECIMATOR_AVG_EN
    if (mode_new == ACQ_MODE_AVG) last_new = (CntW'(1) << shift_new) - CntW'(1);
`endif
  end

  always_comb begin
    cnt_d = cnt_eff;
    if (din_valid) cnt_d = frame_end ? '0 : cnt_eff + CntW'(1);
  end

  acq_minmax #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_minmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (frame_start),
    .update (din_valid && !frame_start),
    .din    (din),
    .run_min(run_min),
    .run_max(run_max)
  );

  always_comb begin
    res_min = first_sel;
    res_max = first_sel;
    unique case (mode_sel)
      ACQ_MODE_PEAK: begin
        res_min = run_min;
        res_max = run_max;
      end
`ifdef ACQ_DECIMATOR_AVG_EN
      ACQ_MODE_AVG: begin
        res_min = avg_res;
        res_max = avg_res;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      last_q       <= '0;
      mode_q       <= ACQ_MODE_SAMPLE;
      first_q      <= '0;
      dout_min_q   <= '0;
      dout_max_q   <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dout_valid_q <= frame_end;
      if (frame_start) begin
        mode_q  <= mode_new;
        last_q  <= last_new;
        first_q <= din;
      end
      if (frame_end) begin
        dout_min_q <= res_min;
        dout_max_q <= res_max;
      end
    end
  end

  assign dout_min   = dout_min_q;
  assign dout_max   = dout_max_q;
  assign dout_valid = dout_valid_q;

endmodule
